// File: rtl/cam_pixel_streamer.sv
// ---------------------------------------------------------------------------
// cam_pixel_streamer
//   Streams one frame out of a frame memory in raster order. It issues one
//   read per pixel, inserts HBLANK idle cycles between lines, and presents
//   each returned pixel on cam_*_o with a one-cycle cam_done_o strobe. The
//   strobe appears two cycles after the matching read.
//
//   Optional feature: define CAM_STREAM_TESTPAT_EN to add test_pat_i. When
//   test_pat_i is high at start_i, the frame is a generated pattern:
//   R=col, G=row, B=col^row. No memory reads are issued, but timing and
//   strobes stay the same as a memory frame.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous reset, active low
//   start_i      one-cycle frame request; honoured only when idle
//   test_pat_i   (CAM_STREAM_TESTPAT_EN only) pattern select, sampled at start
//   mem_rd_o     frame memory read strobe
//   mem_addr_o   frame memory read address (0 when not reading)
//   mem_data_i   read data {R,G,B}, valid the cycle after mem_rd_o
//   cam_*_o      pixel colour, held between strobes
//   cam_done_o   pixel valid strobe
//   busy_o       frame in progress
//   frame_done_o strobe with the last cam_done_o of the frame
// ---------------------------------------------------------------------------
module cam_pixel_streamer #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int HBLANK = 4,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
`ifdef CAM_STREAM_TESTPAT_EN
  input  logic              test_pat_i,
`endif
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [23:0]       mem_data_i,
  output logic [7:0]        cam_red_o,
  output logic [7:0]        cam_green_o,
  output logic [7:0]        cam_blue_o,
  output logic              cam_done_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_LINE, S_HBLANK, S_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        cnt_q, cnt_d;     // shared by HBLANK and DRAIN waits
  logic              pix_vld;          // a pixel is issued this cycle
  logic              pix_last;         // ... and it is the final one of the frame

  // Read pipeline: stage 1 = data returning from memory, stage 2 = on outputs
  logic [2:1]        vld_pipe_q, vld_pipe_d;
  logic [2:1]        last_pipe_q, last_pipe_d;
  logic [23:0]       cam_q, cam_d;
  logic [23:0]       pix_src;

`ifdef CAM_STREAM_TESTPAT_EN
  logic              pat_q, pat_d;
  logic [23:0]       pat_pix_q, pat_pix_d;
  logic [7:0]        col8, row8;
`endif

  // ---------------- frame sequencing FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    pix_vld  = 1'b0;
    pix_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LINE;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
        end
      end
      S_LINE: begin
        pix_vld = 1'b1;
        addr_d  = addr_q + 1'b1;
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (row_q == ROW_LAST) begin
            pix_last = 1'b1;
            state_d  = S_DRAIN;
            cnt_d    = 8'd1;             // two drain cycles
          end else begin
            row_d   = row_q + 1'b1;
            state_d = S_HBLANK;
            cnt_d   = 8'(HBLANK - 1);    // HBLANK idle cycles
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_HBLANK: begin
        if (cnt_q == 8'd0) state_d = S_LINE;
        else               cnt_d   = cnt_q - 1'b1;
      end
      S_DRAIN: begin
        if (cnt_q == 8'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- test pattern source (optional) ----------------
`ifdef CAM_STREAM_TESTPAT_EN
  assign col8 = 8'(col_q);
  assign row8 = 8'(row_q);

  always_comb begin
    pat_d     = pat_q;
    pat_pix_d = pat_pix_q;
    if (state_q == S_IDLE && start_i) pat_d = test_pat_i;
    // Captured alongside the read so it lines up with memory data in stage 1
    if (pix_vld) pat_pix_d = {col8, row8, col8 ^ row8};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q     <= 1'b0;
      pat_pix_q <= '0;
    end else begin
      pat_q     <= pat_d;
      pat_pix_q <= pat_pix_d;
    end
  end

  assign mem_rd_o = pix_vld & ~pat_q;
  assign pix_src  = pat_q ? pat_pix_q : mem_data_i;
`else
  assign mem_rd_o = pix_vld;
  assign pix_src  = mem_data_i;
`endif

  assign mem_addr_o = mem_rd_o ? addr_q : '0;

  // ---------------- read pipeline ----------------
  always_comb begin
    vld_pipe_d  = {vld_pipe_q[1], pix_vld};
    last_pipe_d = {last_pipe_q[1], pix_last};
    cam_d       = vld_pipe_q[1] ? pix_src : cam_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      cam_q       <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      cam_q       <= cam_d;
    end
  end

  assign cam_red_o    = cam_q[23:16];
  assign cam_green_o  = cam_q[15:8];
  assign cam_blue_o   = cam_q[7:0];
  assign cam_done_o   = vld_pipe_q[2];
  assign frame_done_o = vld_pipe_q[2] & last_pipe_q[2];
  assign busy_o       = (state_q != S_IDLE);

endmodule
